aes_round_engine: RTL and testbench

Parametrised, iterative AES block-cipher engine. Performs one round per cycle, and supports both encryption and decryption selected per block. Key length (128/192/256) is fixed by a parameter. It sits between the message buffer (valid/ready in) and the output formatter (valid/ready out). Round keys come from an external key-schedule store, addressed by round index.

---
 rtl/aes_round_engine.sv | 183 ++++++++++++++++++
 tb/tb_aes_round_engine.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES engine: one round per clock, encrypt or decrypt selected per block.
// Optional macro AES_PIPE_ACCEPT_EN lets DONE hand off directly to the next block.
module aes_round_engine #(
    parameter int KEY_BITS = 128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_dir,
    input  logic [127:0]        in_block,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        roundKey,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] ONE_IDX = RK_IDX_W'(1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
    end
    if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
        $error("aes_round_engine: RK_IDX_W too narrow for NR");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t                state, next_state;
    logic [127:0]          stm;
    logic                  dir;
    logic [RK_IDX_W-1:0]   rnd;
    logic                  accept;
    logic                  last_round;
    logic [127:0]          sub_in, sub_out, shifted, mix_in, mix_out, round_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Multiplicative inverse in GF(2^8) as x^254; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, base;
        r    = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gmul(base, base);
            r    = gmul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic inv, input logic [7:0] x);
        logic [7:0] t;
        if (inv) begin
            t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
            return gf_inv(t);
        end
        t = gf_inv(x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic inv, input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_byte(inv, s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic inv, input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    // Each output byte is a rotated dot product with {2,3,1,1} or {14,11,13,9}
    function automatic logic [127:0] mix_columns(input logic inv, input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  coef;
        logic [7:0]   acc;
        coef = inv ? 32'h0e0b0d09 : 32'h02030101;
        o    = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-8*(4*c+(r+k)%4) -: 8], coef[31-8*k -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    assign last_round = (rnd == NR_IDX);
    assign sub_in     = dir ? shift_rows(1'b1, stm) : stm;
    assign sub_out    = sub_bytes(dir, sub_in);
    assign shifted    = shift_rows(1'b0, sub_out);
    // Decrypt adds the round key before InvMixColumns, encrypt after MixColumns
    assign mix_in     = dir ? (sub_out ^ roundKey) : shifted;
    assign mix_out    = mix_columns(dir, mix_in);
    assign round_next = last_round ? (dir ? (sub_out ^ roundKey) : (shifted ^ roundKey))
                                   : (dir ? mix_out : (mix_out ^ roundKey));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        rk_idx     = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = in_dir ? NR_IDX : '0;
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = dir ? (NR_IDX - rnd) : rnd;
                if (last_round) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef AES_PIPE_ACCEPT_EN
                in_ready  = out_ready;
                rk_idx    = in_dir ? NR_IDX : '0;
`endif
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        in_ready = in_ready && reset;
        if (in_valid && in_ready) next_state = ROUND;
    end

    assign accept    = in_valid && in_ready;
    assign out_block = stm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stm <= '0;
            dir <= 1'b0;
            rnd <= '0;
        end else if (accept) begin
            stm <= in_block ^ roundKey;
            dir <= in_dir;
            rnd <= ONE_IDX;
        end else if (state == ROUND) begin
            stm <= round_next;
            if (!last_round) rnd <= rnd + ONE_IDX;
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: AES-128/192/256 instances against a table-driven AES model.
`timescale 1ns/1ps
module tb_aes_round_engine;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_dir    [3];
    logic [127:0] in_block  [3];
    logic [3:0]   rk_idx    [3];
    logic [127:0] round_key [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_block [3];
    logic         busy      [3];

    logic [127:0] rk_table [3][16];
    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];

    int checks = 0;
    int errors = 0;
    int cycle_count = 0;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_PIPE_ACCEPT_EN
    localparam int B2B_PERIOD = 11;
`else
    localparam int B2B_PERIOD = 12;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_engine #(.KEY_BITS(128 + 64 * g), .RK_IDX_W(4)) dut (
            .clk(clk), .reset(reset),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_dir(in_dir[g]),
            .in_block(in_block[g]), .rk_idx(rk_idx[g]), .roundKey(round_key[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_block(out_block[g]), .busy(busy[g])
        );
        assign round_key[g] = rk_table[g][rk_idx[g]];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box built by walking the multiplicative group with generator 3 and its inverse
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    endtask

    task automatic expand_key(input int g, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = 4 + 2 * g; nr = nk + 6; rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_table[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] s, input bit inv);
        for (int i = 0; i < 16; i++)
            s[127-8*i -: 8] = inv ? inv_sbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
        return s;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int r, c, sc;
        for (int i = 0; i < 16; i++) begin
            r = i % 4; c = i / 4;
            sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*i -: 8] = s[127-8*(r + 4*sc) -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s, input bit inv);
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            if (!inv) o[127-32*c -: 32] = {
                gm(a0,2) ^ gm(a1,3) ^ a2 ^ a3, a0 ^ gm(a1,2) ^ gm(a2,3) ^ a3,
                a0 ^ a1 ^ gm(a2,2) ^ gm(a3,3), gm(a0,3) ^ a1 ^ a2 ^ gm(a3,2)};
            else o[127-32*c -: 32] = {
                gm(a0,14) ^ gm(a1,11) ^ gm(a2,13) ^ gm(a3,9),
                gm(a0,9) ^ gm(a1,14) ^ gm(a2,11) ^ gm(a3,13),
                gm(a0,13) ^ gm(a1,9) ^ gm(a2,14) ^ gm(a3,11),
                gm(a0,11) ^ gm(a1,13) ^ gm(a2,9) ^ gm(a3,14)};
        end
        return o;
    endfunction

    function automatic logic [127:0] model_encrypt(input int g, input logic [127:0] b);
        int nr = 10 + 2 * g;
        b = b ^ rk_table[g][0];
        for (int r = 1; r < nr; r++) b = m_mix(m_shift(m_sub(b, 0), 0), 0) ^ rk_table[g][r];
        return m_shift(m_sub(b, 0), 0) ^ rk_table[g][nr];
    endfunction

    function automatic logic [127:0] model_decrypt(input int g, input logic [127:0] b);
        int nr = 10 + 2 * g;
        b = b ^ rk_table[g][nr];
        for (int r = nr - 1; r >= 1; r--) b = m_mix(m_sub(m_shift(b, 1), 1) ^ rk_table[g][r], 1);
        return m_sub(m_shift(b, 1), 1) ^ rk_table[g][0];
    endfunction

    function automatic logic [255:0] kat_key(input int g);
        logic [255:0] k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        if (g == 0) k[127:0] = '0;
        if (g == 1) k[63:0] = '0;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic run_block(input int g, input logic d, input logic [127:0] blk,
                             input logic [127:0] exp, input string tag);
        int nr, edges;
        logic [3:0] exp_idx;
        nr = 10 + 2 * g;
        in_valid[g] = 1'b1; in_dir[g] = d; in_block[g] = blk; out_ready[g] = 1'b1;
        #1;
        checks++;
        if (in_ready[g] !== 1'b1) begin
            errors++; $display("[TB] FAIL %s accept_ready: got %b want 1", tag, in_ready[g]);
        end
        exp_idx = d ? 4'(nr) : 4'd0;
        checks++;
        if (rk_idx[g] !== exp_idx) begin
            errors++; $display("[TB] FAIL %s rk_idx_accept: got %0d want %0d", tag, rk_idx[g], exp_idx);
        end
        tick();
        in_valid[g] = 1'b0;
        edges = 0;
        while (out_valid[g] !== 1'b1 && edges < 40) begin
            exp_idx = d ? 4'(nr - 1 - edges) : 4'(edges + 1);
            checks++;
            if (rk_idx[g] !== exp_idx) begin
                errors++; $display("[TB] FAIL %s rk_idx_round%0d: got %0d want %0d", tag, edges + 1, rk_idx[g], exp_idx);
            end
            tick();
            edges++;
        end
        checks++;
        if (edges != nr) begin
            errors++; $display("[TB] FAIL %s latency: got %0d want %0d", tag, edges, nr);
        end
        checks++;
        if (out_valid[g] !== 1'b1 || out_block[g] !== exp) begin
            errors++; $display("[TB] FAIL %s out_block: got %h want %h", tag, out_block[g], exp);
        end
`ifdef AES_PIPE_ACCEPT_EN
        exp_idx = d ? 4'(nr) : 4'd0;
`else
        exp_idx = 4'd0;
`endif
        checks++;
        if (rk_idx[g] !== exp_idx) begin
            errors++; $display("[TB] FAIL %s rk_idx_done: got %0d want %0d", tag, rk_idx[g], exp_idx);
        end
        tick();
        checks++;
        if (out_valid[g] !== 1'b0 || busy[g] !== 1'b0) begin
            errors++; $display("[TB] FAIL %s release: out_valid %b busy %b want 0 0", tag, out_valid[g], busy[g]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (out_valid[g] !== 1'b0 || busy[g] !== 1'b0 || in_ready[g] !== 1'b0 || out_block[g] !== 128'h0) begin
                errors++;
                $display("[TB] FAIL reset_state[%0d]: valid %b busy %b ready %b block %h want 0 0 0 0",
                         g, out_valid[g], busy[g], in_ready[g], out_block[g]);
            end
        end
        reset = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || busy[g] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset[%0d]: ready %b valid %b busy %b want 1 0 0", g, in_ready[g], out_valid[g], busy[g]);
            end
            in_dir[g] = 1'b1;
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (rk_idx[g] !== 4'(10 + 2 * g)) begin
                errors++; $display("[TB] FAIL idle_rk_idx_dec[%0d]: got %0d want %0d", g, rk_idx[g], 10 + 2 * g);
            end
            in_dir[g] = 1'b0;
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (rk_idx[g] !== 4'd0) begin
                errors++; $display("[TB] FAIL idle_rk_idx_enc[%0d]: got %0d want 0", g, rk_idx[g]);
            end
        end
        tick();
    endtask

    task automatic test_known_answer();
        logic [127:0] ct [3];
        ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int g = 0; g < 3; g++) begin
            expand_key(g, kat_key(g));
            run_block(g, 1'b0, PT, ct[g], $sformatf("kat_enc%0d", 128 + 64 * g));
            run_block(g, 1'b1, ct[g], PT, $sformatf("kat_dec%0d", 128 + 64 * g));
        end
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] blk, exp;
        logic d;
        for (int g = 0; g < 3; g++) begin
            for (int n = 0; n < 4; n++) begin
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                blk = {$urandom, $urandom, $urandom, $urandom};
                d = 1'($urandom_range(0, 1));
                expand_key(g, key);
                exp = d ? model_decrypt(g, blk) : model_encrypt(g, blk);
                run_block(g, d, blk, exp, $sformatf("rand%0d_%0d_dir%0d", 128 + 64 * g, n, d));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp;
        int edges;
        expand_key(0, kat_key(0));
        exp = model_encrypt(0, PT);
        in_valid[0] = 1'b1; in_dir[0] = 1'b0; in_block[0] = PT; out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        edges = 0;
        while (out_valid[0] !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_reach_done: out_valid %b want 1", out_valid[0]);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = ~in_valid[0];
            in_block[0] = {$urandom, $urandom, $urandom, $urandom};
            in_dir[0] = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_block[0] !== exp || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: valid %b ready %b busy %b block %h want 1 0 1 %h",
                         i, out_valid[0], in_ready[0], busy[0], out_block[0], exp);
            end
            tick();
        end
        in_valid[0] = 1'b0; in_dir[0] = 1'b0; out_ready[0] = 1'b1;
        #1;
        checks++;
        if (out_valid[0] !== 1'b1 || out_block[0] !== exp) begin
            errors++; $display("[TB] FAIL bp_emit: valid %b block %h want 1 %h", out_valid[0], out_block[0], exp);
        end
        tick();
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_no_second: valid %b busy %b want 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        expand_key(0, kat_key(0));
        in_valid[0] = 1'b1; in_dir[0] = 1'b0; in_block[0] = PT; out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_assert: valid %b busy %b ready %b want 0 0 0", out_valid[0], busy[0], in_ready[0]);
        end
        repeat (2) begin
            tick();
            checks++;
            if (out_valid[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset_hold: out_valid %b want 0", out_valid[0]);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_release: ready %b busy %b want 1 0", in_ready[0], busy[0]);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (out_valid[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset_quiet%0d: out_valid %b want 0", i, out_valid[0]);
            end
            tick();
        end
        run_block(0, 1'b0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "midreset_next");
    endtask

    task automatic test_back_to_back();
        logic [127:0] blks [4];
        logic [127:0] exps [4];
        int stamps [4];
        int next, outs, cycles;
        logic acc;
        expand_key(0, kat_key(0));
        for (int i = 0; i < 4; i++) begin
            blks[i] = {$urandom, $urandom, $urandom, $urandom};
            exps[i] = model_encrypt(0, blks[i]);
        end
        out_ready[0] = 1'b1; in_dir[0] = 1'b0;
        next = 0; outs = 0; cycles = 0;
        while (outs < 4 && cycles < 200) begin
            in_valid[0] = (next < 4);
            if (next < 4) in_block[0] = blks[next];
            #1;
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0] === 1'b1) begin
                checks++;
                if (out_block[0] !== exps[outs]) begin
                    errors++; $display("[TB] FAIL b2b_data%0d: got %h want %h", outs, out_block[0], exps[outs]);
                end
                stamps[outs] = cycle_count;
                outs++;
            end
            tick();
            cycles++;
            if (acc) next++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (outs != 4) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d want 4", outs);
        end
        for (int i = 1; i < outs; i++) begin
            checks++;
            if (stamps[i] - stamps[i-1] != B2B_PERIOD) begin
                errors++; $display("[TB] FAIL b2b_period%0d: got %0d want %0d", i, stamps[i] - stamps[i-1], B2B_PERIOD);
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; in_dir[g] = 1'b0; in_block[g] = '0; out_ready[g] = 1'b0;
            for (int r = 0; r < 16; r++) rk_table[g][r] = '0;
        end
        build_tables();
        test_reset();
        test_known_answer();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
